pipe_credit_sink: RTL
=====================

PIPE_CREDIT_SINK -- requirements
Module: pipe_credit_sink

Interface
REQ-001 Parameter WIDTH, default 32: payload width of the pipeline result.
REQ-002 Parameter DEPTH, default 4: FIFO entries; legal range 2..16, any value; full throughput requires DEPTH >= pipeline latency + 1.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 issue_ready  output  1  credit available; upstream may assert in_valid into the valid-only pipeline this cycle.
REQ-006 issue_valid  input  1  copy of the in_valid presented to the pipeline this cycle.
REQ-007 pipe_valid  input  1  pipeline out_valid: a result arrives this cycle.
REQ-008 pipe_data  input  WIDTH  pipeline result, qualified by pipe_valid.
REQ-009 out_valid  output  1  downstream data available.
REQ-010 out_ready  input  1  downstream accepts data.
REQ-011 out_data  output  WIDTH  head-of-FIFO payload, qualified by out_valid.
REQ-012 err  output  1  sticky protocol-error flag.

Function
REQ-013 Converts the valid-only, non-stallable pipeline output into a ready/valid stream, using credits so in-flight results can never be lost.
REQ-014 count (0..DEPTH): FIFO occupancy; inflight (0..DEPTH): issues accepted but not yet returned; both $clog2(DEPTH+1) bits wide.
REQ-015 issue_ready = (count + inflight) < DEPTH; driven from registers only; no combinational path from any input.
REQ-016 Issue accepted when issue_valid & issue_ready: inflight +1.
REQ-017 pipe_valid: inflight -1; issue and return in the same cycle leave inflight unchanged.
REQ-018 push = pipe_valid; pop = out_valid & out_ready; count += push - pop; simultaneous push and pop leaves count unchanged and is legal at every occupancy, including full.
REQ-019 Write pointer and read pointer each advance by 1 per push/pop and wrap from DEPTH-1 to 0.
REQ-020 out_valid = (count != 0); out_data = storage at read pointer (first-word fall-through).
REQ-021 Latency: a result with pipe_valid at cycle t is visible on out_valid/out_data at t+1; no same-cycle bypass.
REQ-022 Order preserved; every pushed word is output exactly once.
REQ-023 out_data holds its value while out_valid & !out_ready.
REQ-024 The following set err: issue_valid while issue_ready=0 (not counted); pipe_valid with inflight=0 (inflight stays 0); push when count=DEPTH with no pop (word dropped, state unchanged).
REQ-025 err remains 1 until rst.

Reset
REQ-026 On rst: count=0, inflight=0, pointers=0, err=0; FIFO contents are not cleared.
REQ-027 During and after rst: out_valid=0, issue_ready=1; rst overrides every simultaneous issue, push and pop.
REQ-028 Reset mid-operation discards buffered and in-flight results; the pipeline's valid flops clear on the same rst.

Structure
REQ-029 Shared package pipe_credit_pkg holds the count-width function and the DEPTH legality constants.
REQ-030 Storage and pointers live in one sub-module, pipe_credit_fifo (parameters WIDTH, DEPTH; push/pop/full/empty); credit logic and err stay in the top.

Verification
REQ-031 rst, then 4 issues back-to-back with latency 1, out_ready=1 -> issue_ready stays 1; outputs appear one cycle after each pipe_valid, in order.
REQ-032 DEPTH=4, out_ready=0, issue every cycle -> issue_ready falls after the 4th accepted issue; 4 words buffered; err=0.
REQ-033 Full FIFO, out_ready=1 and pipe_valid the same cycle -> count stays 4; the 4 old words then the new word emerge in order.
REQ-034 Force pipe_valid with inflight=0 -> err=1 next cycle and stays 1 until rst.
REQ-035 rst asserted with 3 buffered and 1 in flight -> next cycle out_valid=0, issue_ready=1, err=0.
REQ-036 Random issue and out_ready, 10k cycles, DEPTH in {2,3,4,16} -> scoreboard matches, err=0, pointers wrap correctly.

Source files
------------

// File: rtl/pipe_credit_pkg.sv
// pipe_credit_pkg: shared sizing helpers and legal DEPTH bounds for the credit sink
package pipe_credit_pkg;
    localparam int DEPTH_MIN = 2;
    localparam int DEPTH_MAX = 16;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/pipe_credit_fifo.sv
// pipe_credit_fifo: first-word fall-through storage with wrapping pointers and occupancy
module pipe_credit_fifo
    import pipe_credit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wdata,
    output logic [WIDTH-1:0]          rdata,
    output logic                      full,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   count
);
    localparam int CW = cnt_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;

    assign rdata = mem[rptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;

    // Payload storage is left uncleared by reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wptr] <= wdata;
    end

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            if (pop) rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/pipe_credit_sink.sv
// pipe_credit_sink: credit-gated buffer turning a non-stallable pipeline output into ready/valid
module pipe_credit_sink
    import pipe_credit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic             issue_ready,
    input  logic             issue_valid,
    input  logic             pipe_valid,
    input  logic [WIDTH-1:0] pipe_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             err
);
    localparam int CW = cnt_w(DEPTH);

    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic          full;
    logic          empty;
    logic          accept;
    logic          ret;
    logic          push;
    logic          pop;

    // Credit check uses only registered state so issue_ready has no input-to-output path
    assign issue_ready = (CW + 1)'(count) + (CW + 1)'(inflight) < (CW + 1)'(DEPTH);
    assign accept      = issue_valid & issue_ready;
    assign ret         = pipe_valid & (inflight != '0);
    assign out_valid   = !empty;
    assign pop         = out_valid & out_ready;
    assign push        = pipe_valid & (!full | pop);

    pipe_credit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (pipe_data),
        .rdata (out_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // In-flight credits: taken on accepted issue, returned when the result lands
    always_ff @(posedge clk) begin
        if (rst) inflight <= '0;
        else inflight <= inflight + CW'(accept) - CW'(ret);
    end

    // Sticky error on issue without credit, unexpected result, or overflow drop
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else err <= err | (issue_valid & !issue_ready) | (pipe_valid & (inflight == '0))
                        | (pipe_valid & full & !pop);
    end
endmodule
